// File: rtl/vertex_light_accum.sv
// vertex_light_accum
// Folds per-light diffuse cosines with per-light intensities and an ambient
// term into one fp32 brightness. It uses one combinational fp32 multiplier
// and one fp32 adder with a registered pipeline of ADD_LAT stages. One vertex
// is processed at a time.
// The fp32 arithmetic rounds to nearest, ties to even. Subnormal operands and
// subnormal results are flushed to zero.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   vertex handshake; in_vid, in_dot, in_two_sided, light_en
//                       are captured on accept
//   light_int, La_int   per-light and ambient intensities; not captured, so they
//                       must stay stable from accept until the output handshake
//   out_valid/out_ready result handshake; out_vid, Brightness held while stalled
//
// State table:
//   IDLE  | waiting for a vertex, in_ready=1
//   ISSUE | light k: skip it if disabled, otherwise launch acc + c*int_k
//   WAIT  | adder pipeline in flight; acc is updated in the last WAIT cycle
//   OUT   | result presented until out_ready
module vertex_light_accum #(
  parameter int IDW     = 8,
  parameter int NL      = 4,
  parameter int ADD_LAT = 1,
  parameter int SAT_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDW-1:0]    in_vid,
  input  logic [NL*32-1:0]  in_dot,
  input  logic              in_two_sided,
  input  logic [NL-1:0]     light_en,
  input  logic [NL*32-1:0]  light_int,
  input  logic [31:0]       La_int,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDW-1:0]    out_vid,
  output logic [31:0]       Brightness
);

  localparam int KW = (NL > 1) ? $clog2(NL) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NL - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(ADD_LAT);
  localparam logic [31:0]   ONE    = 32'h3F800000;
  localparam logic [31:0]   QNAN   = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [CW-1:0]     wcnt;
  logic [31:0]       acc;
  logic [NL*32-1:0]  dot_q;
  logic              two_q;
  logic [NL-1:0]     en_q;
  logic [31:0]       pipe [ADD_LAT];

  logic [31:0] dot_k, int_k, cos_k, prod, sum, add_res;
  logic        en_k;

  function automatic logic [31:0] sat(input logic [31:0] x);
    // Catches +Inf and +NaN as well, since their magnitude bits exceed 1.0.
    if (SAT_EN != 0 && !x[31] && x[30:0] > 31'h3F800000) return ONE;
    return x;
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea, eb;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              g, st;
    logic [24:0]       r;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    p  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    r = {2'b01, m} + 25'(g & (st | m[0]));
    e = e + $signed({9'b0, r[24]});
    if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0) ||
        (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00))
      return QNAN;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'b0};
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'b0};
    if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
    if (e <= 10'sd0) return {s, 31'b0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [53:0]       sh;
    logic [26:0]       mx, my, n;
    logic [27:0]       s;
    logic signed [9:0] e;
    logic [4:0]        lz;
    logic              found;
    logic [24:0]       r;
    logic              a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[30:23] == 0 && b[30:23] == 0) return {a[31] & b[31], 31'b0};
    if (a[30:23] == 0) return b;
    if (b[30:23] == 0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    // Three extra bits (guard, round, sticky); anything shifted past them folds into sticky.
    sh = {1'b1, y[22:0], 3'b000, 27'b0} >> ((d > 8'd27) ? 8'd27 : d);
    my = {sh[53:28], sh[27] | (|sh[26:0])};
    e  = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        n = {s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        n = s[26:0];
      end
    end else begin
      n     = mx - my;
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && n[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      n = n << lz;
      e = e - $signed({5'b0, lz});
    end
    if (n == 0) return 32'h0;
    r = {2'b01, n[25:3]} + 25'(n[2] & ((|n[1:0]) | n[3]));
    e = e + $signed({9'b0, r[24]});
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'b0};
    if (e <= 10'sd0) return {x[31], 31'b0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  assign dot_k   = dot_q[{k, 5'b0} +: 32];
  assign int_k   = light_int[{k, 5'b0} +: 32];
  assign en_k    = en_q[k];
  // One-sided lighting clamps back-facing cosines to +0; two-sided takes |cos|.
  assign cos_k   = two_q ? {1'b0, dot_k[30:0]} : (dot_k[31] ? 32'h0 : dot_k);
  assign prod    = fp_mul(cos_k, int_k);
  assign sum     = fp_add(acc, prod);
  assign add_res = pipe[ADD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ADD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= sum;
      for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      wcnt       <= '0;
      acc        <= '0;
      dot_q      <= '0;
      two_q      <= 1'b0;
      en_q       <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_vid    <= '0;
      Brightness <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            out_vid  <= in_vid;
            dot_q    <= in_dot;
            two_q    <= in_two_sided;
            en_q     <= light_en;
            acc      <= La_int;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (en_k) begin
            wcnt  <= C_LOAD;
            state <= WAIT;
          end else if (k == K_LAST) begin
            Brightness <= sat(acc);
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            k <= k + KW'(1);
          end
        end
        WAIT: begin
          if (wcnt == CW'(1)) begin
            acc <= add_res;
            if (k == K_LAST) begin
              Brightness <= sat(add_res);
              out_valid  <= 1'b1;
              state      <= OUT;
            end else begin
              k     <= k + KW'(1);
              state <= ISSUE;
            end
          end else begin
            wcnt <= wcnt - CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_light_accum.sv
module tb_vertex_light_accum;

  localparam int NL = 4;
  localparam int AL = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_vid;
  logic [127:0] in_dot;
  logic         in_two_sided;
  logic [3:0]   light_en;
  logic [127:0] light_int;
  logic [31:0]  La_int;
  logic         out_ready;

  logic        in_ready_s, out_valid_s, in_ready_n, out_valid_n;
  logic [7:0]  out_vid_s, out_vid_n;
  logic [31:0] bright_s, bright_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vertex_light_accum #(.IDW(8), .NL(NL), .ADD_LAT(AL), .SAT_EN(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_vid(in_vid), .in_dot(in_dot), .in_two_sided(in_two_sided),
    .light_en(light_en), .light_int(light_int), .La_int(La_int),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_vid(out_vid_s),
    .Brightness(bright_s)
  );

  vertex_light_accum #(.IDW(8), .NL(NL), .ADD_LAT(AL), .SAT_EN(0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_vid(in_vid), .in_dot(in_dot), .in_two_sided(in_two_sided),
    .light_en(light_en), .light_int(light_int), .La_int(La_int),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_vid(out_vid_n),
    .Brightness(bright_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact conversions only: bench values are small multiples of 1/16.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:0] == 31'h0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], e[10:0], f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic real model(input logic [127:0] dot, input logic [127:0] li,
                                input logic [31:0] la, input logic [3:0] en, input logic two);
    real acc, c;
    acc = f2r(la);
    for (int i = 0; i < NL; i++) begin
      if (en[i]) begin
        c = f2r(dot[32*i +: 32]);
        if (c < 0.0) c = two ? -c : 0.0;
        acc = acc + c * f2r(li[32*i +: 32]);
      end
    end
    return acc;
  endfunction

  task automatic send(input logic [7:0] vid, input logic [127:0] dot, input logic [127:0] li,
                      input logic [31:0] la, input logic [3:0] en, input logic two,
                      input logic [31:0] exp_s, input logic [31:0] exp_n,
                      input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!in_ready_s && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", {31'b0, in_ready_s}, 32'd1);
    in_vid = vid; in_dot = dot; light_int = li; La_int = la;
    light_en = en; in_two_sided = two; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vid = ~vid;
    in_dot = ~dot;
    n = 1;
    while (!out_valid_s && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    check("valid_n", {31'b0, out_valid_n}, 32'd1);
    check("bright_sat", bright_s, exp_s);
    check("bright_nosat", bright_n, exp_n);
    check("out_vid", {24'b0, out_vid_s}, {24'b0, vid});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid_s}, 32'd1);
      check("hold_bright", bright_s, exp_s);
      check("hold_vid", {24'b0, out_vid_s}, {24'b0, vid});
      check("hold_ready", {31'b0, in_ready_s}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", {31'b0, out_valid_s}, 32'd0);
    check("post_ready", {31'b0, in_ready_s}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]   vid;
    logic [127:0] dot;
    logic [127:0] li;
    logic [31:0]  la;
    logic [3:0]   en;
    logic         two;
    logic [31:0]  exp_s;
    logic [31:0]  exp_n;
    int           lat;
  } vec_t;

  vec_t tbl[8];

  localparam logic [31:0] H  = 32'h3F000000;
  localparam logic [31:0] NH = 32'hBF000000;
  localparam logic [31:0] O  = 32'h3F800000;

  initial begin
    logic [127:0] rd, rl;
    logic [31:0]  rla, es, en_bits;
    logic [3:0]   ren;
    logic         rtwo;
    real          ref_v;
    int           seen;

    tbl[0] = '{8'h5A, {4{H}}, {4{H}}, 32'h0, 4'hF, 1'b0, O, O, 9};
    tbl[1] = '{8'h11, {H, H, NH, H}, {4{H}}, 32'h0, 4'hF, 1'b0, 32'h3F400000, 32'h3F400000, 9};
    tbl[2] = '{8'h12, {H, H, NH, H}, {4{H}}, 32'h0, 4'hF, 1'b1, O, O, 9};
    tbl[3] = '{8'h13, {4{H}}, {4{H}}, 32'h0, 4'b0101, 1'b0, H, H, 7};
    tbl[4] = '{8'h14, {4{O}}, {4{O}}, H, 4'hF, 1'b0, O, 32'h40900000, 9};
    tbl[5] = '{8'h15, {4{H}}, {4{H}}, 32'hBF800000, 4'h0, 1'b0, 32'hBF800000, 32'hBF800000, 5};
    tbl[6] = '{8'h16, {4{H}}, {4{H}}, 32'h7F800000, 4'h0, 1'b0, O, 32'h7F800000, 5};
    tbl[7] = '{8'h17, {4{H}}, {4{H}}, 32'hC0000000, 4'hF, 1'b0, 32'hBF800000, 32'hBF800000, 9};

    rst = 1'b1; in_valid = 1'b0; in_vid = '0; in_dot = '0; in_two_sided = 1'b0;
    light_en = '0; light_int = '0; La_int = '0; out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid_s}, 32'd0);
    check("rst_ready", {31'b0, in_ready_s}, 32'd0);
    check("rst_bright", bright_s, 32'd0);
    check("rst_vid", {24'b0, out_vid_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'b0, in_ready_s}, 32'd1);

    for (int i = 0; i < 8; i++)
      send(tbl[i].vid, tbl[i].dot, tbl[i].li, tbl[i].la, tbl[i].en, tbl[i].two,
           tbl[i].exp_s, tbl[i].exp_n, tbl[i].lat, 0);

    // Backpressure then an immediate second vertex.
    send(8'h21, {4{H}}, {4{H}}, 32'h0, 4'hF, 1'b0, O, O, 9, 5);
    send(8'h22, {4{H}}, {4{H}}, 32'h0, 4'b0011, 1'b0, H, H, 7, 0);

    // Reset during the WAIT of light 2.
    in_vid = 8'h33; in_dot = {4{H}}; light_int = {4{H}}; La_int = 32'h0;
    light_en = 4'hF; in_two_sided = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_vid", {24'b0, out_vid_s}, 32'd0);
    check("midrst_valid", {31'b0, out_valid_s}, 32'd0);
    check("midrst_bright", bright_s, 32'd0);
    check("midrst_ready", {31'b0, in_ready_s}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_after", {31'b0, in_ready_s}, 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_s || out_valid_n) seen++;
    end
    check("no_spurious_valid", seen, 0);
    send(8'h34, {4{H}}, {4{H}}, 32'h0, 4'hF, 1'b1, O, O, 9, 0);

    // Random vectors against the arithmetic model.
    for (int v = 0; v < 24; v++) begin
      for (int i = 0; i < NL; i++) begin
        rd[32*i +: 32] = r2f(real'(int'($urandom_range(32)) - 16) / 16.0);
        rl[32*i +: 32] = r2f(real'($urandom_range(32)) / 16.0);
      end
      rla     = r2f(real'(int'($urandom_range(32)) - 16) / 16.0);
      en_bits = $urandom;
      ren     = en_bits[3:0];
      rtwo    = en_bits[4];
      ref_v   = model(rd, rl, rla, ren, rtwo);
      es      = r2f(ref_v > 1.0 ? 1.0 : ref_v);
      send(8'(v + 64), rd, rl, rla, ren, rtwo, es, r2f(ref_v),
           1 + NL + AL * $countones(ren), int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
